// File: rtl/sprite_compositor.sv
// Sprite layer compositor: double-buffered per-channel sprite configuration, sprite ROM
// address generation, fixed-priority texel merge over background, player collision flags.
module sprite_compositor #(
  parameter int N_SPR   = 8,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int AW      = 14,
  parameter int CW      = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [XW-1:0]            col_addr,
  input  logic [YW-1:0]            row_addr,
  input  logic                     cfg_we,
  input  logic [$clog2(N_SPR)-1:0] cfg_idx,
  input  logic [XW-1:0]            cfg_x,
  input  logic [YW-1:0]            cfg_y,
  input  logic [XW-1:0]            cfg_w,
  input  logic [YW-1:0]            cfg_h,
  input  logic                     cfg_en,
  input  logic [CW-1:0]            cfg_key,
  output logic [N_SPR*AW-1:0]      spr_addr,
  input  logic [N_SPR*CW-1:0]      spr_rdata,
  input  logic [CW-1:0]            bg_data,
  output logic [CW-1:0]            pix_out,
  output logic                     pix_out_valid,
  output logic [N_SPR-1:0]         coll_flags,
  output logic                     coll_irq
);

  localparam int               PW          = XW + YW;
  localparam logic [N_SPR-1:0] PLAYER_MASK = N_SPR'(1);

  logic [XW-1:0]    r_pendX   [N_SPR];
  logic [YW-1:0]    r_pendY   [N_SPR];
  logic [XW-1:0]    r_pendW   [N_SPR];
  logic [YW-1:0]    r_pendH   [N_SPR];
  logic [CW-1:0]    r_pendKey [N_SPR];
  logic [N_SPR-1:0] r_pendEn;

  logic [XW-1:0]    r_actX    [N_SPR];
  logic [YW-1:0]    r_actY    [N_SPR];
  logic [XW-1:0]    r_actW    [N_SPR];
  logic [YW-1:0]    r_actH    [N_SPR];
  logic [CW-1:0]    r_actKey  [N_SPR];
  logic [N_SPR-1:0] r_actEn;

  logic [N_SPR-1:0] w_sel;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_SPR; k++) begin
      w_sel[k] = cfg_we && (int'(cfg_idx) == k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SPR; k++) begin
        r_pendX[k]   <= '0;
        r_pendY[k]   <= '0;
        r_pendW[k]   <= '0;
        r_pendH[k]   <= '0;
        r_pendKey[k] <= '0;
      end
      r_pendEn <= '0;
    end else begin
      for (int k = 0; k < N_SPR; k++) begin
        if (w_sel[k]) begin
          r_pendX[k]   <= cfg_x;
          r_pendY[k]   <= cfg_y;
          r_pendW[k]   <= cfg_w;
          r_pendH[k]   <= cfg_h;
          r_pendKey[k] <= cfg_key;
          r_pendEn[k]  <= cfg_en;
        end
      end
    end
  end

  // A write landing in the commit cycle bypasses the pending set straight into the active set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SPR; k++) begin
        r_actX[k]   <= '0;
        r_actY[k]   <= '0;
        r_actW[k]   <= '0;
        r_actH[k]   <= '0;
        r_actKey[k] <= '0;
      end
      r_actEn <= '0;
    end else if (frame_start) begin
      for (int k = 0; k < N_SPR; k++) begin
        r_actX[k]   <= w_sel[k] ? cfg_x   : r_pendX[k];
        r_actY[k]   <= w_sel[k] ? cfg_y   : r_pendY[k];
        r_actW[k]   <= w_sel[k] ? cfg_w   : r_pendW[k];
        r_actH[k]   <= w_sel[k] ? cfg_h   : r_pendH[k];
        r_actKey[k] <= w_sel[k] ? cfg_key : r_pendKey[k];
        r_actEn[k]  <= w_sel[k] ? cfg_en  : r_pendEn[k];
      end
    end
  end

  logic [XW:0]      w_xEnd [N_SPR];
  logic [YW:0]      w_yEnd [N_SPR];
  logic [XW-1:0]    w_dx   [N_SPR];
  logic [YW-1:0]    w_dy   [N_SPR];
  logic [PW-1:0]    w_full [N_SPR];
  logic [AW-1:0]    w_addr [N_SPR];
  logic [N_SPR-1:0] w_hit;

  // Box ends are one bit wider than the coordinates so x+w past the screen edge never wraps.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N_SPR; k++) begin
      w_xEnd[k] = {1'b0, r_actX[k]} + {1'b0, r_actW[k]};
      w_yEnd[k] = {1'b0, r_actY[k]} + {1'b0, r_actH[k]};
      w_dx[k]   = col_addr - r_actX[k];
      w_dy[k]   = row_addr - r_actY[k];
      w_full[k] = PW'(w_dy[k]) * PW'(r_actW[k]) + PW'(w_dx[k]);
      w_hit[k]  = r_actEn[k] && (r_actW[k] != '0) && (r_actH[k] != '0)
                  && ({1'b0, col_addr} >= {1'b0, r_actX[k]}) && ({1'b0, col_addr} < w_xEnd[k])
                  && ({1'b0, row_addr} >= {1'b0, r_actY[k]}) && ({1'b0, row_addr} < w_yEnd[k]);
      w_addr[k] = w_hit[k] ? AW'(w_full[k]) : '0;
    end
  end

  logic [N_SPR-1:0]    r_hit1;
  logic [N_SPR*CW-1:0] r_key1;
  logic                r_valid1;
  logic [N_SPR*AW-1:0] r_sprAddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit1    <= '0;
      r_key1    <= '0;
      r_valid1  <= 1'b0;
      r_sprAddr <= '0;
    end else begin
      r_hit1   <= w_hit;
      r_valid1 <= pix_valid;
      for (int k = 0; k < N_SPR; k++) begin
        r_sprAddr[k*AW +: AW] <= w_addr[k];
        r_key1[k*CW +: CW]    <= r_actKey[k];
      end
    end
  end

  logic [N_SPR-1:0]    r_hitPipe   [ROM_LAT];
  logic [N_SPR*CW-1:0] r_keyPipe   [ROM_LAT];
  logic [ROM_LAT-1:0]  r_validPipe;

  // Delay the S1 side-band by the ROM latency so it lines up with the returned texels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        r_hitPipe[s] <= '0;
        r_keyPipe[s] <= '0;
      end
      r_validPipe <= '0;
    end else begin
      r_hitPipe[0]   <= r_hit1;
      r_keyPipe[0]   <= r_key1;
      r_validPipe[0] <= r_valid1;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_hitPipe[s]   <= r_hitPipe[s-1];
        r_keyPipe[s]   <= r_keyPipe[s-1];
        r_validPipe[s] <= r_validPipe[s-1];
      end
    end
  end

  logic [N_SPR-1:0] w_opaque;
  logic [N_SPR-1:0] w_collHit;
  logic [CW-1:0]    w_texel;
  logic             w_valid2;

  // Ascending scan so the highest-index opaque channel wins.
  always_comb begin
    w_valid2 = r_validPipe[ROM_LAT-1];
    w_texel  = bg_data;
    w_opaque = '0;
    for (int k = 0; k < N_SPR; k++) begin
      w_opaque[k] = r_hitPipe[ROM_LAT-1][k]
                    && (spr_rdata[k*CW +: CW] != r_keyPipe[ROM_LAT-1][k*CW +: CW]);
      if (w_opaque[k]) begin
        w_texel = spr_rdata[k*CW +: CW];
      end
    end
    w_collHit = (w_valid2 && w_opaque[0]) ? (w_opaque & ~PLAYER_MASK) : '0;
  end

  logic [CW-1:0]    r_pixOut;
  logic             r_pixValid;
  logic [N_SPR-1:0] r_acc;
  logic [N_SPR-1:0] r_collFlags;
  logic             r_collIrq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixOut   <= '0;
      r_pixValid <= 1'b0;
    end else begin
      r_pixOut   <= w_valid2 ? w_texel : '0;
      r_pixValid <= w_valid2;
    end
  end

  // Hits arriving in the frame_start cycle land in the freshly cleared accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_collFlags <= '0;
      r_collIrq   <= 1'b0;
    end else if (frame_start) begin
      r_collFlags <= r_acc & ~PLAYER_MASK;
      r_collIrq   <= |(r_acc & ~PLAYER_MASK);
      r_acc       <= w_collHit;
    end else begin
      r_collIrq <= 1'b0;
      r_acc     <= r_acc | w_collHit;
    end
  end

  assign spr_addr      = r_sprAddr;
  assign pix_out       = r_pixOut;
  assign pix_out_valid = r_pixValid;
  assign coll_flags    = r_collFlags;
  assign coll_irq      = r_collIrq;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a coordinate-level reference model queues expected
// pixels and collision results, and an independent monitor compares what the DUT emits.
module tb_sprite_compositor;
  localparam int N   = 8;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int AW  = 14;
  localparam int CW  = 12;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              pix_valid;
  logic [XW-1:0]     col_addr;
  logic [YW-1:0]     row_addr;
  logic              cfg_we;
  logic [2:0]        cfg_idx;
  logic [XW-1:0]     cfg_x;
  logic [YW-1:0]     cfg_y;
  logic [XW-1:0]     cfg_w;
  logic [YW-1:0]     cfg_h;
  logic              cfg_en;
  logic [CW-1:0]     cfg_key;
  logic [N*AW-1:0]   spr_addr;
  logic [N*CW-1:0]   spr_rdata;
  logic [CW-1:0]     bg_data;
  logic [CW-1:0]     pix_out;
  logic              pix_out_valid;
  logic [N-1:0]      coll_flags;
  logic              coll_irq;

  sprite_compositor #(.N_SPR(N), .XW(XW), .YW(YW), .AW(AW), .CW(CW), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .col_addr(col_addr), .row_addr(row_addr), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_en(cfg_en),
    .cfg_key(cfg_key), .spr_addr(spr_addr), .spr_rdata(spr_rdata), .bg_data(bg_data),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .coll_flags(coll_flags),
    .coll_irq(coll_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] pix;
    longint        cyc;
  } exp_t;

  exp_t         pixQ[$];
  logic [N:0]   collQ[$];
  int           maskQ[$];
  longint       cyc = 0;
  int           nCompare = 0;
  int           nFail = 0;
  int           bgMode = 0;
  logic         fsSeen;

  int mPx[N], mPy[N], mPw[N], mPh[N], mPk[N], mPe[N];
  int mAx[N], mAy[N], mAw[N], mAh[N], mAk[N], mAe[N];
  int mAcc = 0;

  bit wrReq = 0;
  int wrIdx, wrX, wrY, wrW, wrH, wrEn, wrKey;

  // ROM contents: every fifth texel of a channel equals that channel's usual key.
  function automatic int romKey(int k);
    return 'h418 + k * 8;
  endfunction

  function automatic int texFn(int k, int a);
    if (a % 5 == 0) return romKey(k);
    return (a * 37 + k * 337 + 1) & 'hFFF;
  endfunction

  function automatic int bgFn(int c, int r);
    if (bgMode == 0) return 'h123;
    return (c * 3 + r * 17 + 5) & 'hFFF;
  endfunction

  // External ROMs with one cycle of read latency; background follows the scan coordinate.
  int c1Col, c1Row;
  always @(posedge clk) begin
    c1Col   <= int'(col_addr);
    c1Row   <= int'(row_addr);
    bg_data <= CW'(bgFn(c1Col, c1Row));
    for (int k = 0; k < N; k++) begin
      spr_rdata[k*CW +: CW] <= CW'(texFn(k, int'(spr_addr[k*AW +: AW])));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) fsSeen <= 1'b0;
    else     fsSeen <= frame_start;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompare++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference pixel: sprites drawn in ascending channel order over the background.
  task automatic modelPixel(input int col, input int row, output int pix, output int opq);
    int a, t;
    pix = bgFn(col, row);
    opq = 0;
    for (int k = 0; k < N; k++) begin
      if (mAe[k] != 0 && mAw[k] != 0 && mAh[k] != 0 &&
          col >= mAx[k] && col < mAx[k] + mAw[k] && row >= mAy[k] && row < mAy[k] + mAh[k]) begin
        a = ((row - mAy[k]) * mAw[k] + (col - mAx[k])) & 'h3FFF;
        t = texFn(k, a);
        if (t != mAk[k]) begin
          pix = t;
          opq |= (1 << k);
        end
      end
    end
  endtask

  task automatic setWrite(input int k, input int x, input int y, input int w, input int h,
                          input int en, input int key);
    wrReq = 1; wrIdx = k; wrX = x; wrY = y; wrW = w; wrH = h; wrEn = en; wrKey = key & 'hFFF;
  endtask

  // One clock of stimulus; pixels issued two cycles before a frame_start count for the new frame.
  task automatic applyStimulus(input bit fs, input bit pv, input int col, input int row);
    int pix, opq, mask, popped;
    frame_start = fs;
    pix_valid   = pv;
    col_addr    = XW'(col);
    row_addr    = YW'(row);
    cfg_we      = wrReq;
    cfg_idx     = 3'(wrIdx);
    cfg_x       = XW'(wrX);
    cfg_y       = YW'(wrY);
    cfg_w       = XW'(wrW);
    cfg_h       = YW'(wrH);
    cfg_en      = (wrEn != 0);
    cfg_key     = CW'(wrKey);
    modelPixel(col, row, pix, opq);
    if (pv) pixQ.push_back('{CW'(pix), cyc});
    mask = (pv && (opq & 1) != 0) ? (opq & ~1) : 0;
    maskQ.push_back(mask);
    popped = 0;
    if (maskQ.size() == 3) popped = maskQ.pop_front();
    if (wrReq) begin
      mPx[wrIdx] = wrX; mPy[wrIdx] = wrY; mPw[wrIdx] = wrW;
      mPh[wrIdx] = wrH; mPe[wrIdx] = wrEn; mPk[wrIdx] = wrKey;
    end
    if (fs) begin
      collQ.push_back({mAcc != 0, N'(mAcc)});
      mAcc = 0;
      mAx = mPx; mAy = mPy; mAw = mPw; mAh = mPh; mAe = mPe; mAk = mPk;
    end
    mAcc |= popped;
    wrReq = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0);
  endtask

  task automatic clearModel();
    for (int k = 0; k < N; k++) begin
      mPx[k] = 0; mPy[k] = 0; mPw[k] = 0; mPh[k] = 0; mPk[k] = 0; mPe[k] = 0;
    end
    mAx = mPx; mAy = mPy; mAw = mPw; mAh = mPh; mAk = mPk; mAe = mPe;
    mAcc = 0;
    pixQ.delete();
    collQ.delete();
    maskQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 64'(pix_out_valid), 0);
    checkOutput({tag, "_pix"}, 64'(pix_out), 0);
    checkOutput({tag, "_flags"}, 64'(coll_flags), 0);
    checkOutput({tag, "_irq"}, 64'(coll_irq), 0);
    checkOutput({tag, "_addr"}, 64'(spr_addr), 0);
  endtask

  task automatic midReset();
    #2 rst = 1'b1;
    #1 checkAllZero("reset_mid");
    clearModel();
    frame_start = 0; pix_valid = 0; cfg_we = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pickCoord(output int col, output int row);
    int k;
    k = $urandom_range(0, N - 1);
    if (mAw[k] == 0 || mAh[k] == 0 || $urandom_range(0, 3) == 0) begin
      col = $urandom_range(0, 1023);
      row = $urandom_range(0, 511);
    end else begin
      col = mAx[k] + $urandom_range(0, mAw[k] + 3) - 2;
      row = mAy[k] + $urandom_range(0, mAh[k] + 3) - 2;
      if (col < 0) col = 0;
      if (col > 1023) col = 1023;
      if (row < 0) row = 0;
      if (row > 511) row = 511;
    end
  endtask

  task automatic randomWrite();
    int k;
    k = $urandom_range(0, N - 1);
    setWrite(k, $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 63),
             $urandom_range(0, 63), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 1) != 0) ? romKey(k) : int'($urandom_range(0, 4095)));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or latches collision flags.
  always @(negedge clk) begin
    exp_t       e;
    logic [N:0] c;
    if (!rst) begin
      if (pix_out_valid) begin
        if (pixQ.size() == 0) checkOutput("unexpected_pixel", 1, 0);
        else begin
          e = pixQ.pop_front();
          checkOutput("pix_out", 64'(pix_out), 64'(e.pix));
          checkOutput("latency", 64'(cyc - e.cyc), LAT);
        end
      end else begin
        checkOutput("pix_out_idle", 64'(pix_out), 0);
      end
      if (fsSeen) begin
        if (collQ.size() == 0) checkOutput("unexpected_frame", 1, 0);
        else begin
          c = collQ.pop_front();
          checkOutput("coll_flags", 64'(coll_flags), 64'(c[N-1:0]));
          checkOutput("coll_irq", 64'(coll_irq), 64'(c[N]));
        end
      end else begin
        checkOutput("coll_irq_idle", 64'(coll_irq), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int col, row;
    rst = 1'b1; frame_start = 0; pix_valid = 0; col_addr = '0; row_addr = '0;
    cfg_we = 0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0;
    cfg_en = 0; cfg_key = '0;
    clearModel();
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset_init");
    rst = 1'b0;

    $display("[TB] unconfigured scan over constant background");
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, $urandom_range(0, 639), $urandom_range(0, 479));
    idle(4);
    bgMode = 1;

    $display("[TB] channel 2 box and key");
    setWrite(2, 100, 50, 47, 41, 1, 'h428);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 100, 50);
    applyStimulus(0, 1, 146, 90);
    applyStimulus(0, 1, 147, 90);
    applyStimulus(0, 1, 146, 91);
    applyStimulus(0, 1, 99, 50);
    for (int i = 0; i < 150; i++) applyStimulus(0, 1, $urandom_range(95, 150), $urandom_range(45, 95));

    $display("[TB] overlapping channels 1 and 3");
    setWrite(1, 300, 200, 20, 20, 1, romKey(1));
    applyStimulus(0, 0, 0, 0);
    setWrite(3, 310, 205, 20, 20, 1, romKey(3));
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 200; i++) applyStimulus(0, 1, $urandom_range(295, 335), $urandom_range(195, 230));

    $display("[TB] mid-frame move of channel 1");
    setWrite(1, 200, 200, 20, 20, 1, romKey(1));
    for (int i = 0; i < 150; i++) applyStimulus(0, 1, $urandom_range(195, 335), $urandom_range(198, 222));
    applyStimulus(1, 1, 205, 205);
    for (int i = 0; i < 150; i++) applyStimulus(0, 1, $urandom_range(195, 335), $urandom_range(198, 222));

    $display("[TB] player collision with channel 4");
    setWrite(0, 10, 10, 3, 3, 1, romKey(0));
    applyStimulus(0, 0, 0, 0);
    setWrite(4, 11, 12, 3, 3, 1, romKey(4));
    applyStimulus(1, 0, 0, 0);
    for (int r = 0; r <= 20; r++)
      for (int c = 0; c <= 20; c++) applyStimulus(0, 1, c, r);
    setWrite(4, 400, 400, 3, 3, 1, romKey(4));
    applyStimulus(1, 1, 12, 12);
    idle(3);
    for (int r = 0; r <= 20; r++)
      for (int c = 0; c <= 20; c++) applyStimulus(0, 1, c, r);
    applyStimulus(1, 0, 0, 0);
    idle(3);

    $display("[TB] right-edge sprite without coordinate wrap");
    setWrite(5, 1000, 0, 40, 20, 1, romKey(5));
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 60; i++) applyStimulus(0, 1, $urandom_range(990, 1023), $urandom_range(0, 25));

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 250; p++) begin
        if ($urandom_range(0, 19) == 0) randomWrite();
        pickCoord(col, row);
        applyStimulus(0, ($urandom_range(0, 7) != 0), col, row);
      end
      if ($urandom_range(0, 1) != 0) randomWrite();
      pickCoord(col, row);
      applyStimulus(1, 1, col, row);
    end

    $display("[TB] reset during active scan");
    for (int p = 0; p < 40; p++) begin
      pickCoord(col, row);
      applyStimulus(0, 1, col, row);
    end
    midReset();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) applyStimulus(0, 1, $urandom_range(0, 1023), $urandom_range(0, 511));
    applyStimulus(1, 0, 0, 0);

    idle(LAT + 2);
    for (int i = 0; i < 20; i++) begin
      if (pixQ.size() == 0 && collQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drain_pixels", 64'(pixQ.size()), 0);
    checkOutput("drain_frames", 64'(collQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nCompare, nFail);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-channel sprite layer compositor between the VGA scan-coordinate source and the `vgac` pixel input. Each channel holds a position, a size and a transparency key for one sprite. Per pixel it generates the sprite ROM addresses, merges the returned texels over the background by fixed priority, and accumulates per-frame player-versus-sprite collision flags. Sprite configuration is double-buffered and commits only at frame start, so movement never tears mid-frame.

## Interface
Parameters:
- `N_SPR`, 8: number of sprite channels. Channel 0 is the player; a higher index has higher draw priority.
- `XW`, 10: column coordinate width.
- `YW`, 9: row coordinate width.
- `AW`, 14: sprite ROM address width per channel.
- `CW`, 12: colour width (RGB444).
- `ROM_LAT`, 1: sprite/background ROM read latency in cycles (≥1).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse at the start of each frame. Commits the configuration and latches the collision flags.
- `pix_valid` in 1: the coordinate this cycle is a visible pixel.
- `col_addr` in XW, `row_addr` in YW: scan coordinate.
- `cfg_we` in 1: write strobe for the pending configuration.
- `cfg_idx` in $clog2(N_SPR): channel being written. Out-of-range writes are ignored.
- `cfg_x` in XW, `cfg_y` in YW, `cfg_w` in XW, `cfg_h` in YW, `cfg_en` in 1, `cfg_key` in CW: channel fields.
- `spr_addr` out N_SPR*AW: per-channel ROM address. Channel k occupies bits [k*AW +: AW].
- `spr_rdata` in N_SPR*CW: per-channel ROM data, returned ROM_LAT cycles after `spr_addr`.
- `bg_data` in CW: background texel, aligned with `spr_rdata`.
- `pix_out` out CW, `pix_out_valid` out 1: composited pixel.
- `coll_flags` out N_SPR: collision flags from the previous frame. Bit 0 is always 0.
- `coll_irq` out 1: one-cycle pulse when the latched flags are nonzero.

## Operation
- Configuration uses two register sets, pending and active, each holding x, y, w, h, en and key for every channel.
  - `cfg_we` writes the pending set only.
  - On `frame_start`, active <= pending. A `cfg_we` in the same cycle as `frame_start` is included in the commit.
- Stage S1 (registered) computes, per channel k, using the active set:
  - Hit test: hit_k = en_k && w_k != 0 && h_k != 0 && col ≥ x_k && col < x_k+w_k && row ≥ y_k && row < y_k+h_k.
  - The comparisons use XW+1 / YW+1 bits, so x+w never wraps.
  - Address: spr_addr_k = (row−y_k)*w_k + (col−x_k), truncated to AW bits, when hit_k; otherwise 0.
  - hit_k and `pix_valid` are piped alongside.
- Stage S2 (after ROM_LAT): opaque_k = hit_k && spr_rdata_k != key_k.
  - The key used is the one captured at S1 and piped with the pixel.
- Stage S3 (registered) selects the output pixel:
  - `pix_out` = texel of the highest-index opaque channel, else `bg_data`.
  - `pix_out_valid` = piped `pix_valid`.
  - When the piped `pix_valid` is 0, `pix_out` is 0.
- Collision:
  - When a piped `pix_valid` is set with opaque_0 && opaque_k (k≥1), set acc[k].
  - On `frame_start`: `coll_flags` <= acc, with acc[0] forced to 0; acc <= 0.
  - Also on `frame_start`: `coll_irq` <= |acc.
  - An S2 hit in the same cycle as `frame_start` is accumulated into the cleared accumulator, i.e. it counts for the new frame.
- Pixels already in flight at `frame_start` keep their S1-captured hit, address and key. No pixel mixes old and new configuration.

## Timing
- Latency from coordinate input to `pix_out`: L = 2 + ROM_LAT cycles (3 with ROM_LAT = 1). Throughput is one pixel per cycle, with no stalls.
- `spr_addr` is valid 1 cycle after the coordinate input. The external ROM and `bg_data` must present data ROM_LAT cycles later.
- A configuration write becomes visible to S1 on the first coordinate after the next `frame_start` edge.
- `coll_flags` update 1 cycle after `frame_start`. `coll_irq` is high for exactly that cycle.
- Reset values:
  - Pending and active sets: all 0, so every channel is disabled.
  - Pipelines, `spr_addr`, `pix_out`, `pix_out_valid`, acc, `coll_flags`, `coll_irq`: all 0.
- Reset asserted mid-frame clears the pipeline immediately. Output resumes L cycles after the first `pix_valid` following reset release.

## Test plan
- Reset, then drive `pix_valid` over a 640×480 scan with bg_data = 0x123 and no configuration -> every `pix_out` = 0x123, at latency 3.
- Channel 2 at x=100, y=50, w=47, h=41, key=0x428:
  - Coordinate (100,50) -> spr_addr_2 = 0. Coordinate (146,90) -> 1926. Coordinate (147,90) -> hit 0.
  - A texel equal to 0x428 -> background shown.
- Channels 1 and 3 overlap, both opaque, texels 0xAAA and 0xBBB -> `pix_out` = 0xBBB.
- Write channel 1 with x=200 mid-frame -> the rest of the frame renders at the old x. Frame after `frame_start` -> renders at x=200.
- Channels 0 and 4 overlap opaque on one pixel -> at the next `frame_start`, `coll_flags` = 0x10 and `coll_irq` pulses 1 cycle. Following frame with no overlap -> flags return to 0.
- Assert `rst` during an active scan -> `pix_out_valid` drops the same cycle, all outputs read 0, and the active set is cleared.
